uart_byte_receiver: RTL and testbench

- Serial front end directly upstream of control_module's command parser.
- Converts the asynchronous rx line (8N1, LSB first, idle high) into parallel bytes.
- Delivers bytes over a valid/ready handshake.
- Reports framing errors, overruns and a busy flag; control_module consumes rx_data/rx_valid and drives rx_ready.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_byte_receiver.sv | 149 ++++++++++++++
 tb/tb_uart_byte_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame constants, FSM state
// encodings and bit-timing helpers.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // Counter reload that lands the start-bit sample in the middle of the bit.
  function automatic int half_bit_reload(input int bit_clks);
    return bit_clks / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line plus falling-edge detect.
// All flops reset to the idle-high line level so reset release never fakes a start edge.
module uart_rx_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic rx_async,
  output logic rx_s,
  output logic rx_fall
);

  logic sync_q1;
  logic sync_q2;
  logic rx_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_q1 <= rx_async;
      sync_q2 <= sync_q1;
      rx_prev <= sync_q2;
    end
  end

  assign rx_s    = sync_q2;
  assign rx_fall = rx_prev & ~sync_q2;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Define UART_BYTE_RECEIVER_MAJORITY_EN for 3-sample majority voting (needs BIT_CLKS >= 6).
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int BIT_CLKS    = 50,
  parameter int COUNT_WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_running,
  output logic       frame_error,
  output logic       overrun
);

  localparam logic [COUNT_WIDTH-1:0] HALF_RELOAD = COUNT_WIDTH'(half_bit_reload(BIT_CLKS));
  localparam logic [COUNT_WIDTH-1:0] FULL_RELOAD = COUNT_WIDTH'(BIT_CLKS - 1);

  logic                      rx_s;
  logic                      rx_fall;
  logic [2:0]                state;
  logic [COUNT_WIDTH-1:0]    bit_cnt;
  logic [UART_IDX_W-1:0]     bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      bit_tick;
  logic                      sample_bit;
  logic                      byte_done;

  uart_rx_sync u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .rx_async (uart_rx),
    .rx_s     (rx_s),
    .rx_fall  (rx_fall)
  );

`ifdef UART_BYTE_RECEIVER_MAJORITY_EN
  // rx_hist1/rx_hist2 hold rx_s as seen at counter values 1 and 2.
  logic rx_hist1;
  logic rx_hist2;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_hist1 <= 1'b1;
      rx_hist2 <= 1'b1;
    end else begin
      rx_hist1 <= rx_s;
      rx_hist2 <= rx_hist1;
    end
  end

  assign sample_bit = (rx_s & rx_hist1) | (rx_s & rx_hist2) | (rx_hist1 & rx_hist2);
`else
  assign sample_bit = rx_s;
`endif

  assign bit_tick   = (bit_cnt == '0);
  assign byte_done  = (state == ST_STOP) && bit_tick && sample_bit;
  assign rx_running = (state != ST_IDLE);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state   <= ST_START;
            bit_cnt <= HALF_RELOAD;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            if (!sample_bit) begin
              state   <= ST_DATA;
              bit_cnt <= FULL_RELOAD;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - COUNT_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift_reg[bit_idx] <= sample_bit;
            bit_cnt            <= FULL_RELOAD;
            if (bit_idx == UART_IDX_W'(UART_DATA_BITS - 1)) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + UART_IDX_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt - COUNT_WIDTH'(1);
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (sample_bit) begin
              state <= ST_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= ST_WAIT_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - COUNT_WIDTH'(1);
          end
        end
        // A held-low line (break) must return high before a new start is armed.
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-entry buffer: a completion may replace the byte only if it is being accepted.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at BIT_CLKS=50.
// Define UART_BYTE_RECEIVER_MAJORITY_EN here as well as for the RTL to check the voting build.
module tb_uart_byte_receiver;

  localparam int BIT_CLKS   = 50;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       tb_clk_baudrate = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_running;
  logic       frame_error;
  logic       overrun;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         start_cyc;
  int         valid_rises;
  int         fe_cnt;
  int         ov_cnt;
  int         run_cnt;
  int         rise_cyc;
  logic [7:0] last_data;
  logic       prev_valid = 1'b0;
  logic [7:0] spike_expect;

  uart_byte_receiver #(
    .BIT_CLKS    (BIT_CLKS),
    .COUNT_WIDTH (8)
  ) dut (
    .clk_in      (tb_clk_baudrate),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_running  (rx_running),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 tb_clk_baudrate = ~tb_clk_baudrate;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock, then observe the settled outputs for that cycle.
  task automatic tick();
    @(posedge tb_clk_baudrate);
    #1;
    cyc++;
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      last_data = rx_data;
      rise_cyc  = cyc;
    end
    prev_valid = rx_valid;
    fe_cnt  += int'(frame_error);
    ov_cnt  += int'(overrun);
    run_cnt += int'(rx_running);
  endtask

  task automatic clear_counts();
    valid_rises = 0;
    fe_cnt      = 0;
    ov_cnt      = 0;
    run_cnt     = 0;
    rise_cyc    = -1;
    last_data   = 8'h00;
  endtask

  // Drives the first n_cycles of a frame; spike_at forces the line high for one cycle.
  task automatic drive_frame(input logic [7:0] data, input logic stop_val,
                             input int spike_at, input int n_cycles);
    int   b;
    logic bit_val;
    for (int c = 0; c < n_cycles; c++) begin
      b = c / BIT_CLKS;
      if (b == 0)      bit_val = 1'b0;
      else if (b <= 8) bit_val = data[b-1];
      else             bit_val = stop_val;
      if (c == spike_at) bit_val = 1'b1;
      uart_rx = bit_val;
      tick();
    end
  endtask

  initial begin
    reset    = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    clear_counts();
    repeat (3) tick();
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_running", 32'(rx_running), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    repeat (5) tick();

    // Clean 0x4C with consumer always ready.
    rx_ready = 1'b1;
    clear_counts();
    start_cyc = cyc;
    drive_frame(8'h4C, 1'b1, -1, FRAME_CLKS);
    repeat (20) tick();
    check("t1_valid_rises", 32'(valid_rises), 32'd1);
    check("t1_rx_data", 32'(last_data), 32'h4C);
    check("t1_frame_error", 32'(fe_cnt), 32'd0);
    check("t1_overrun", 32'(ov_cnt), 32'd0);
    check("t1_running_cycles", 32'(run_cnt), 32'd475);
    check("t1_valid_latency", 32'(rise_cyc - start_cyc), 32'd478);
    check("t1_valid_cleared", 32'(rx_valid), 32'h0);

    // 0x52 with a low stop bit, line held low afterwards.
    clear_counts();
    drive_frame(8'h52, 1'b0, -1, FRAME_CLKS);
    repeat (20) tick();
    check("t2_frame_error_pulse", 32'(fe_cnt), 32'd1);
    check("t2_no_valid", 32'(valid_rises), 32'd0);
    check("t2_running_while_low", 32'(rx_running), 32'h1);
    uart_rx = 1'b1;
    repeat (5) tick();
    check("t2_idle_after_high", 32'(rx_running), 32'h0);

    // 20-cycle low glitch: false start.
    clear_counts();
    uart_rx = 1'b0;
    repeat (20) tick();
    uart_rx = 1'b1;
    repeat (60) tick();
    check("t3_no_valid", 32'(valid_rises), 32'd0);
    check("t3_no_error", 32'(fe_cnt), 32'd0);
    check("t3_idle", 32'(rx_running), 32'h0);
    check("t3_start_cycles", 32'(run_cnt), 32'd25);

    // Back-to-back 0x31, 0x32 with consumer stalled.
    rx_ready = 1'b0;
    clear_counts();
    drive_frame(8'h31, 1'b1, -1, FRAME_CLKS);
    check("t4_first_valid", 32'(rx_valid), 32'h1);
    check("t4_first_data", 32'(rx_data), 32'h31);
    drive_frame(8'h32, 1'b1, -1, FRAME_CLKS);
    repeat (20) tick();
    check("t4_overrun_pulse", 32'(ov_cnt), 32'd1);
    check("t4_data_held", 32'(rx_data), 32'h31);
    check("t4_valid_held", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    tick();
    check("t4_accepted", 32'(rx_valid), 32'h0);

    // Reset during bit 4 of 0xA5, then a clean 0x65.
    rx_ready = 1'b0;
    clear_counts();
    drive_frame(8'hA5, 1'b1, -1, 260);
    check("t5_running_before_reset", 32'(rx_running), 32'h1);
    reset = 1'b1;
    #1;
    check("t5_reset_rx_data", 32'(rx_data), 32'h00);
    check("t5_reset_running", 32'(rx_running), 32'h0);
    check("t5_reset_valid", 32'(rx_valid), 32'h0);
    repeat (3) tick();
    reset   = 1'b0;
    uart_rx = 1'b1;
    repeat (10) tick();
    rx_ready = 1'b1;
    clear_counts();
    drive_frame(8'h65, 1'b1, -1, FRAME_CLKS);
    repeat (20) tick();
    check("t5_next_valid", 32'(valid_rises), 32'd1);
    check("t5_next_data", 32'(last_data), 32'h65);

    // One-cycle high spike at the centre sample of bit 0 of 0x00.
`ifdef UART_BYTE_RECEIVER_MAJORITY_EN
    spike_expect = 8'h00;
`else
    spike_expect = 8'h01;
`endif
    clear_counts();
    drive_frame(8'h00, 1'b1, 75, FRAME_CLKS);
    repeat (20) tick();
    check("t6_spike_valid", 32'(valid_rises), 32'd1);
    check("t6_spike_data", 32'(last_data), 32'(spike_expect));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
